// File: rtl/config_pkg.sv
// Shared constants and state type for the ALU packet parser.
package config_pkg;

  localparam logic [7:0] OPCODE_ECHO = 8'hEC;
  localparam logic [7:0] OPCODE_ADD  = 8'hAD;
  localparam logic [7:0] OPCODE_MUL  = 8'h88;
  localparam logic [7:0] OPCODE_DIV  = 8'hD1;

  localparam int unsigned HEADER_LEN = 4;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [3:0] {
    StOpc,
    StRsvd,
    StLenLo,
    StLenHi,
    StEcho,
    StOperand,
    StAluWait,
    StTxResult,
    StDrain
  } parser_state_e;

  function automatic logic is_math_op(input logic [7:0] op);
    return (op == OPCODE_ADD) || (op == OPCODE_MUL) || (op == OPCODE_DIV);
  endfunction

endpackage

// File: rtl/alu_tx_serializer.sv
// Serialises a 32-bit word as four little-endian bytes over a valid/ready port.
module alu_tx_serializer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  // Next-state: load a new word, or advance one byte per accepted transfer.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = 2'd0;
      valid_d = 1'b1;
    end else if (valid_q && tx_ready_i) begin
      if (cnt_q == 2'd3) begin
        valid_d = 1'b0;
      end else begin
        shift_d = {8'h00, shift_q[31:8]};
        cnt_d   = cnt_q + 2'd1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data_o  = shift_q[7:0];
  assign tx_valid_o = valid_q;
  assign done_o     = valid_q && tx_ready_i && (cnt_q == 2'd3);

endmodule

// File: rtl/alu_packet_parser.sv
// Byte-stream packet parser: echoes payloads or folds 32-bit operands through
// add / external multiply / external divide and returns the 4-byte result.
// Optional feature: define ALU_PARSER_LEN_CHECK_EN to reject malformed lengths.
module alu_packet_parser
  import config_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_result_valid_i,
  output logic        err_o
);

  parser_state_e state_q, state_d;
  logic [7:0]  opc_q, opc_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] part_q, part_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        have_acc_q, have_acc_d;
  logic        alu_pend_q, alu_pend_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic        rdy;
  logic        ser_load, ser_valid, ser_done;
  logic [7:0]  ser_data;
  logic [15:0] len_full, rem_hdr;
  logic [31:0] word;
  logic        len_bad, math_bad, last_byte, go_alu;

  assign len_full = {rx_data_i, len_lo_q};
  assign rem_hdr  = (len_full < 16'(HEADER_LEN)) ? 16'd0 : len_full - 16'(HEADER_LEN);
  assign word     = {rx_data_i, part_q};

`ifdef ALU_PARSER_LEN_CHECK_EN
  assign len_bad  = len_full < 16'(HEADER_LEN);
  assign math_bad = (rem_hdr[1:0] != 2'b00) || (rem_hdr < 16'(2 * WORD_BYTES));
`else
  assign len_bad  = 1'b0;
  assign math_bad = 1'b0;
`endif

  // Next-state and handshake outputs for the packet FSM.
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    len_lo_d   = len_lo_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    part_d     = part_q;
    acc_d      = acc_q;
    alu_b_d    = alu_b_q;
    have_acc_d = have_acc_q;
    alu_pend_d = alu_pend_q;
    last_d     = last_q;
    err_d      = 1'b0;
    rdy        = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = ser_data;
    last_byte  = 1'b0;
    go_alu     = 1'b0;

    unique case (state_q)
      StOpc: begin
        rdy = 1'b1;
        if (rx_valid_i) begin
          opc_d      = rx_data_i;
          acc_d      = '0;
          have_acc_d = 1'b0;
          idx_d      = '0;
          part_d     = '0;
          last_d     = 1'b0;
          state_d    = StRsvd;
        end
      end
      StRsvd: begin
        rdy = 1'b1;
        if (rx_valid_i) state_d = StLenLo;
      end
      StLenLo: begin
        rdy = 1'b1;
        if (rx_valid_i) begin
          len_lo_d = rx_data_i;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        rdy = 1'b1;
        if (rx_valid_i) begin
          rem_d = rem_hdr;
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = StOpc;
          end else if (opc_q == OPCODE_ECHO) begin
            state_d = (rem_hdr == 16'd0) ? StOpc : StEcho;
          end else if (is_math_op(opc_q) && !math_bad) begin
            state_d = (rem_hdr == 16'd0) ? StTxResult : StOperand;
          end else begin
            err_d   = 1'b1;
            state_d = (rem_hdr == 16'd0) ? StOpc : StDrain;
          end
        end
      end
      StEcho: begin
        // Zero-latency passthrough: the transmitter back-pressures the receiver.
        rdy        = tx_ready_i;
        tx_valid_o = rx_valid_i;
        tx_data_o  = rx_data_i;
        if (rx_valid_i && tx_ready_i) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = StOpc;
        end
      end
      StOperand: begin
        if (alu_pend_q) begin
          if (alu_ready_i) begin
            alu_pend_d = 1'b0;
            state_d    = StAluWait;
          end
        end else begin
          rdy = 1'b1;
          if (rx_valid_i) begin
            rem_d     = rem_q - 16'd1;
            idx_d     = idx_q + 2'd1;
            last_byte = (rem_q == 16'd1);
            case (idx_q)
              2'd0: part_d[7:0]   = rx_data_i;
              2'd1: part_d[15:8]  = rx_data_i;
              2'd2: part_d[23:16] = rx_data_i;
              default: ;
            endcase
            if (idx_q == 2'd3) begin
              if (!have_acc_q) begin
                acc_d      = word;
                have_acc_d = 1'b1;
              end else if (opc_q == OPCODE_ADD) begin
                acc_d = acc_q + word;
              end else begin
                go_alu     = 1'b1;
                alu_b_d    = word;
                alu_pend_d = 1'b1;
                last_d     = last_byte;
              end
            end
            // Pending ALU work defers the result until the strobe returns.
            if (last_byte && !go_alu) state_d = StTxResult;
          end
        end
      end
      StAluWait: begin
        if (alu_result_valid_i) begin
          acc_d   = alu_result_i;
          state_d = last_q ? StTxResult : StOperand;
        end
      end
      StTxResult: begin
        tx_valid_o = ser_valid;
        if (ser_done) state_d = StOpc;
      end
      StDrain: begin
        rdy = 1'b1;
        if (rx_valid_i) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = StOpc;
        end
      end
      default: state_d = StOpc;
    endcase

    // Load the serializer with the final accumulator on entry to the result phase.
    ser_load = (state_d == StTxResult) && (state_q != StTxResult);
  end

  // State registers; reset aborts any packet or ALU request in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StOpc;
      opc_q      <= '0;
      len_lo_q   <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      part_q     <= '0;
      acc_q      <= '0;
      alu_b_q    <= '0;
      have_acc_q <= 1'b0;
      alu_pend_q <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      len_lo_q   <= len_lo_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      part_q     <= part_d;
      acc_q      <= acc_d;
      alu_b_q    <= alu_b_d;
      have_acc_q <= have_acc_d;
      alu_pend_q <= alu_pend_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  alu_tx_serializer u_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ser_load),
    .data_i     (acc_d),
    .tx_data_o  (ser_data),
    .tx_valid_o (ser_valid),
    .tx_ready_i (tx_ready_i),
    .done_o     (ser_done)
  );

  assign rx_ready_o  = rdy && !rst_i;
  assign err_o       = err_q;
  assign alu_op_o    = (opc_q == OPCODE_DIV);
  assign alu_a_o     = acc_q;
  assign alu_b_o     = alu_b_q;
  assign alu_valid_o = alu_pend_q;

endmodule

// File: tb/tb_alu_packet_parser.sv
// Scoreboard bench: a packet-level model queues expected tx bytes, ALU requests
// and error pulses; independent monitors compare what the DUT presents.
module tb_alu_packet_parser;
  import config_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_valid_o;
  logic        alu_ready_i;
  logic [31:0] alu_result_i;
  logic        alu_result_valid_i;
  logic        err_o;

  always #5 clk = ~clk;

  alu_packet_parser dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .rx_data_i          (rx_data_i),
    .rx_valid_i         (rx_valid_i),
    .rx_ready_o         (rx_ready_o),
    .tx_data_o          (tx_data_o),
    .tx_valid_o         (tx_valid_o),
    .tx_ready_i         (tx_ready_i),
    .alu_op_o           (alu_op_o),
    .alu_a_o            (alu_a_o),
    .alu_b_o            (alu_b_o),
    .alu_valid_o        (alu_valid_o),
    .alu_ready_i        (alu_ready_i),
    .alu_result_i       (alu_result_i),
    .alu_result_valid_i (alu_result_valid_i),
    .err_o              (err_o)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_tx[$];
  logic [64:0] exp_alu[$];
  logic [7:0]  pl[$];
  int exp_err = 0;
  int obs_err = 0;
  int tx_mode = 0;
  int rdy_delay = 0;
  int res_delay = 0;
  bit gaps = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behaviour of the external arithmetic unit.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'hDEAD_BEEF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
    return 32'($signed(a) / $signed(b));
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    return 32'(sa * sb);
  endfunction

  // Packet-level model computed from the packet rules.
  task automatic model_pkt(input logic [7:0] op, input int len);
    int rem, nw;
    bit math, bad;
    logic [31:0] acc, w;
    rem  = (len < 4) ? 0 : len - 4;
    nw   = rem / 4;
    math = (op == OPCODE_ADD) || (op == OPCODE_MUL) || (op == OPCODE_DIV);
    bad  = 0;
`ifdef ALU_PARSER_LEN_CHECK_EN
    if (len < 4) bad = 1;
    if (math && ((rem % 4) != 0 || nw < 2)) bad = 1;
`endif
    if (bad) begin
      exp_err++;
    end else if (op == OPCODE_ECHO) begin
      foreach (pl[i]) exp_tx.push_back(pl[i]);
    end else if (math) begin
      acc = 32'd0;
      for (int i = 0; i < nw; i++) begin
        w = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
        if (i == 0) acc = w;
        else if (op == OPCODE_ADD) acc = acc + w;
        else begin
          exp_alu.push_back({op == OPCODE_DIV, acc, w});
          acc = (op == OPCODE_MUL) ? ref_mul(acc, w) : ref_div(acc, w);
        end
      end
      for (int i = 0; i < 4; i++) exp_tx.push_back(8'(acc >> (8 * i)));
    end else begin
      exp_err++;
    end
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) pl.push_back(8'(w >> (8 * i)));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps && ($urandom % 4 == 0)) begin
      rx_valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready_o && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) chk("rx_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_alu.size() != 0) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) chk("drain_timeout", 32'(exp_tx.size() + exp_alu.size()), 32'd0);
    repeat (4) @(negedge clk);
    chk("err_pulses", 32'(obs_err), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] op, input int len);
    model_pkt(op, len);
    send_byte(op);
    send_byte(8'($urandom));
    send_byte(8'(len));
    send_byte(8'(len >> 8));
    foreach (pl[i]) send_byte(pl[i]);
    wait_idle();
  endtask

  // tx monitor: compare every accepted byte and hold stability while stalled.
  initial begin
    bit stall;
    logic [7:0] stall_data;
    stall = 0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("tx_hold_valid", 32'(tx_valid_o), 32'd1);
          chk("tx_hold_data", 32'(tx_data_o), 32'(stall_data));
        end
        if (tx_valid_o && tx_ready_i) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx: got %h expected none at %0t", tx_data_o, $time);
          end else begin
            chk("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
          end
        end
        stall      = tx_valid_o && !tx_ready_i;
        stall_data = tx_data_o;
        if (err_o) obs_err++;
      end
    end
  end

  // Transmitter ready pattern.
  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0: tx_ready_i = 1'b1;
        1: tx_ready_i = ~tx_ready_i;
        default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // External ALU stub with programmable accept and result delays.
  initial begin
    logic [31:0] ha, hb, res;
    logic hop;
    logic [64:0] e;
    alu_ready_i = 1'b0;
    alu_result_valid_i = 1'b0;
    alu_result_i = '0;
    forever begin
      @(negedge clk);
      if (alu_valid_o && !rst_i) begin
        ha = alu_a_o;
        hb = alu_b_o;
        hop = alu_op_o;
        repeat (rdy_delay) begin
          @(negedge clk);
          chk("alu_hold_valid", 32'(alu_valid_o), 32'd1);
          chk("alu_hold_a", alu_a_o, ha);
          chk("alu_hold_b", alu_b_o, hb);
        end
        alu_ready_i = 1'b1;
        if (exp_alu.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_alu: got a=%h b=%h expected none", alu_a_o, alu_b_o);
        end else begin
          e = exp_alu.pop_front();
          chk("alu_op", 32'(alu_op_o), 32'(e[64]));
          chk("alu_a", alu_a_o, e[63:32]);
          chk("alu_b", alu_b_o, e[31:0]);
        end
        @(posedge clk);
        #1;
        alu_ready_i = 1'b0;
        res = hop ? ref_div(ha, hb) : ref_mul(ha, hb);
        repeat (res_delay) @(posedge clk);
        #1;
        alu_result_i = res;
        alu_result_valid_i = 1'b1;
        @(posedge clk);
        #1;
        alu_result_valid_i = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops[5];
    logic [7:0] op;
    int plen, len;
    ops[0] = OPCODE_ECHO;
    ops[1] = OPCODE_ADD;
    ops[2] = OPCODE_MUL;
    ops[3] = OPCODE_DIV;
    ops[4] = 8'h55;
    rst_i = 1'b1;
    rx_data_i = '0;
    rx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready_o), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_alu_valid", 32'(alu_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // ECHO "abc", empty ECHO, then a math packet to show parsing resumes.
    pl = {8'h61, 8'h62, 8'h63};
    send_pkt(OPCODE_ECHO, 7);
    pl.delete();
    send_pkt(OPCODE_ECHO, 4);
    pl.delete();
    add_word(32'hFFFF_FFFF); add_word(32'd2); add_word(32'd5);
    send_pkt(OPCODE_ADD, 16);
    chk("add_wrap_sum_bytes_left", 32'(exp_tx.size()), 32'd0);

    // MUL with slow accept and slow result.
    rdy_delay = 3; res_delay = 5;
    pl.delete();
    add_word(32'hFFFF_FFFD); add_word(32'd7);
    send_pkt(OPCODE_MUL, 12);

    // DIV with a toggling transmitter.
    tx_mode = 1; rdy_delay = 0; res_delay = 2;
    pl.delete();
    add_word(32'd100); add_word(32'hFFFF_FFF9);
    send_pkt(OPCODE_DIV, 12);
    tx_mode = 0;

    // Unknown opcode drains, ADD with a partial trailing word, zero-operand ADD.
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(8'h55, 10);
    pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(OPCODE_ADD, 10);
    pl.delete();
    send_pkt(OPCODE_ADD, 4);
    send_pkt(OPCODE_MUL, 2);

    // Reset in the middle of an ADD payload.
    send_byte(OPCODE_ADD); send_byte(8'h00); send_byte(8'd16); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_rx_ready", 32'(rx_ready_o), 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("midrst_alu_valid", 32'(alu_valid_o), 32'd0);
    chk("midrst_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    pl.delete();
    add_word(32'd1); add_word(32'd2);
    send_pkt(OPCODE_ADD, 12);

    // Randomized packets with random back-pressure and ALU timing.
    gaps = 1;
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 4)];
      tx_mode = $urandom_range(0, 2);
      rdy_delay = $urandom_range(0, 3);
      res_delay = $urandom_range(0, 4);
      pl.delete();
      if ($urandom % 8 == 0) begin
        len = $urandom_range(0, 3);
      end else begin
        plen = $urandom_range(0, 14);
        for (int i = 0; i < plen; i++) pl.push_back(8'($urandom));
        len = plen + 4;
      end
      send_pkt(op, len);
    end
    tx_mode = 0;
    repeat (5) @(negedge clk);
    chk("final_tx_queue", 32'(exp_tx.size()), 32'd0);
    chk("final_alu_queue", 32'(exp_alu.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
